// File: rtl/sump_cmd_rx.sv
// SUMP command deframer: assembles 1-byte short and 5-byte long commands from the
// RXD byte stream. Define SUMP_RESET_DETECT_EN to enable the five-zeros soft reset detector.
module sump_cmd_rx #(
    parameter int DW  = 32,
    parameter int TMO = 50_000,
    parameter int TCW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          str_rxd_tvalid,
    input  logic [7:0]    str_rxd_tdata,
    output logic          str_rxd_tready,
    output logic [7:0]    cmd_code,
    output logic [DW-1:0] cmd_data,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic          err_timeout,
    output logic          soft_reset
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [TCW-1:0] TMO_LAST = TCW'((TMO == 0) ? 0 : TMO - 1);

    generate
        if (DW != 32) begin : g_bad_dw
            $error("sump_cmd_rx: DW must be 32");
        end
    endgenerate

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     cnt;
    logic [TCW-1:0] tmo;
    logic           rdy_en;
    logic           byte_acc;
    logic           tmo_hit;

    assign byte_acc = str_rxd_tvalid & str_rxd_tready;
    // An accepted byte in the would-be timeout cycle wins over the timeout.
    assign tmo_hit  = (TMO != 0) && (state == DATA) && !byte_acc && (tmo == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (byte_acc) begin
                    state_nxt = str_rxd_tdata[7] ? DATA : HOLD;
                end
            end
            DATA: begin
                if (byte_acc && (cnt == 2'd3)) begin
                    state_nxt = HOLD;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (cmd_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rdy_en keeps tready low until the first clock after reset release.
    always_comb begin
        str_rxd_tready = rdy_en && (state != HOLD);
        cmd_valid      = (state == HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en      <= 1'b0;
            cnt         <= 2'd0;
            tmo         <= '0;
            cmd_code    <= 8'h00;
            cmd_data    <= '0;
            err_timeout <= 1'b0;
        end else begin
            rdy_en      <= 1'b1;
            err_timeout <= tmo_hit;
            case (state)
                IDLE: begin
                    if (byte_acc) begin
                        cmd_code <= str_rxd_tdata;
                        cmd_data <= '0;
                        cnt      <= 2'd0;
                        tmo      <= '0;
                    end
                end
                DATA: begin
                    if (byte_acc) begin
                        cmd_data[{cnt, 3'b000} +: 8] <= str_rxd_tdata;
                        cnt <= cnt + 2'd1;
                        tmo <= '0;
                    end else begin
                        tmo <= tmo + TCW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SUMP_RESET_DETECT_EN
    logic       cmd_acc;
    logic [2:0] zero_run;

    assign cmd_acc = cmd_valid & cmd_ready;

    // Counts consecutive handshaken 0x00 commands; the fifth fires soft_reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zero_run   <= 3'd0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= 1'b0;
            if (tmo_hit) begin
                zero_run <= 3'd0;
            end else if (cmd_acc) begin
                if (cmd_code == 8'h00) begin
                    if (zero_run == 3'd4) begin
                        soft_reset <= 1'b1;
                        zero_run   <= 3'd0;
                    end else begin
                        zero_run <= zero_run + 3'd1;
                    end
                end else begin
                    zero_run <= 3'd0;
                end
            end
        end
    end
`else
    assign soft_reset = 1'b0;
`endif

endmodule

// File: tb/tb_sump_cmd_rx.sv
// Directed self-checking bench for sump_cmd_rx, built with TMO=20.
module tb_sump_cmd_rx;

    localparam int TMO = 20;
`ifdef SUMP_RESET_DETECT_EN
    localparam int SR_EXP = 1;
`else
    localparam int SR_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        str_rxd_tvalid = 1'b0;
    logic [7:0]  str_rxd_tdata = 8'h00;
    logic        str_rxd_tready;
    logic [7:0]  cmd_code;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic        err_timeout;
    logic        soft_reset;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;
    int sr_cnt  = 0;

    sump_cmd_rx #(.DW(32), .TMO(TMO), .TCW(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .str_rxd_tvalid (str_rxd_tvalid),
        .str_rxd_tdata  (str_rxd_tdata),
        .str_rxd_tready (str_rxd_tready),
        .cmd_code       (cmd_code),
        .cmd_data       (cmd_data),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .err_timeout    (err_timeout),
        .soft_reset     (soft_reset)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_timeout) err_cnt++;
        if (soft_reset) sr_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents a byte and returns #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        str_rxd_tvalid = 1'b1;
        str_rxd_tdata  = b;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = str_rxd_tready;
            @(posedge clk);
            #1;
            n++;
        end
        str_rxd_tvalid = 1'b0;
        if (!ok) check("send_accept", 64'(ok), 64'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int err0;
        int first_err;
        int err_seen;
        int vld_seen;

        // reset state
        #2;
        check("rst_tready", 64'(str_rxd_tready), 64'd0);
        check("rst_valid",  64'(cmd_valid),      64'd0);
        check("rst_code",   64'(cmd_code),       64'd0);
        check("rst_data",   64'(cmd_data),       64'd0);
        check("rst_err",    64'(err_timeout),    64'd0);
        check("rst_soft",   64'(soft_reset),     64'd0);
        idle_cycles(3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rel_tready", 64'(str_rxd_tready), 64'd1);

        // short command
        send_byte(8'h01);
        check("short_valid",  64'(cmd_valid),      64'd1);
        check("short_tready", 64'(str_rxd_tready), 64'd0);
        check("short_code",   64'(cmd_code),       64'h01);
        check("short_data",   64'(cmd_data),       64'h0);
        idle_cycles(1);
        check("short_drop",   64'({cmd_valid, str_rxd_tready}), 64'b01);

        // long command with backpressure
        cmd_ready = 1'b0;
        send_byte(8'hC0);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        check("long_nvalid", 64'(cmd_valid), 64'd0);
        send_byte(8'h12);
        for (int i = 0; i < 10; i++) begin
            check("long_hold", {22'd0, cmd_valid, str_rxd_tready, cmd_code, cmd_data},
                  {22'd0, 1'b1, 1'b0, 8'hC0, 32'h12345678});
            @(posedge clk);
            #1;
        end
        cmd_ready = 1'b1;
        idle_cycles(1);
        check("long_drop", 64'({cmd_valid, str_rxd_tready}), 64'b01);

        // timeout drops a partial long command
        err0 = err_cnt;
        send_byte(8'h80);
        send_byte(8'hAA);
        first_err = 0;
        err_seen  = 0;
        vld_seen  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (err_timeout) begin
                err_seen++;
                if (first_err == 0) first_err = i;
            end
            if (cmd_valid) vld_seen++;
        end
        check("tmo_pulses", 64'(err_seen), 64'd1);
        check("tmo_when",   64'(first_err), 64'd20);
        check("tmo_novld",  64'(vld_seen), 64'd0);
        check("tmo_tready", 64'(str_rxd_tready), 64'd1);
        send_byte(8'h02);
        check("after_tmo_code", 64'(cmd_code), 64'h02);
        check("after_tmo_data", 64'(cmd_data), 64'h0);
        check("after_tmo_vld",  64'(cmd_valid), 64'd1);
        idle_cycles(1);

        // bytes arriving exactly on the last tolerated cycle
        err0 = err_cnt;
        send_byte(8'h80);
        idle_cycles(TMO - 1);
        send_byte(8'h11);
        idle_cycles(TMO - 1);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check("bnd_vld",  64'(cmd_valid), 64'd1);
        check("bnd_code", 64'(cmd_code), 64'h80);
        check("bnd_data", 64'(cmd_data), 64'h44332211);
        check("bnd_noerr", 64'(err_cnt - err0), 64'd0);
        idle_cycles(1);

        // async reset mid-command
        send_byte(8'h81);
        send_byte(8'h11);
        #2;
        rst = 1'b0;
        #1;
        check("arst_outs", {22'd0, cmd_valid, str_rxd_tready, cmd_code, cmd_data}, 64'd0);
        check("arst_err",  64'({err_timeout, soft_reset}), 64'd0);
        err0 = err_cnt;
        idle_cycles(3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h81);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check("arst_code", 64'(cmd_code), 64'h81);
        check("arst_data", 64'(cmd_data), 64'h04030201);
        idle_cycles(TMO + 5);
        check("arst_noerr", 64'(err_cnt - err0), 64'd0);

        // five consecutive 0x00 commands
        err0 = sr_cnt;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h00);
            check("zero_vld", 64'(cmd_valid), 64'd1);
            idle_cycles(1);
            if (i == 4) check("zero5_soft", 64'({soft_reset, cmd_valid}), {62'd0, 1'(SR_EXP), 1'b0});
        end
        check("zero5_pulses", 64'(sr_cnt - err0), 64'(SR_EXP));

        // interrupted run must not fire
        err0 = sr_cnt;
        for (int i = 0; i < 6; i++) begin
            send_byte((i == 4) ? 8'h02 : 8'h00);
            idle_cycles(1);
        end
        check("zero_int_pulses", 64'(sr_cnt - err0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
